// File: rtl/cr_cp0_pkg.sv
// Shared CP0 definitions: cache-invalidate FSM state encoding and default I-cache set count.
package cr_cp0_pkg;

  localparam int CP0_LINE_NUM_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_PA   = 2'd2,
    ST_DONE = 2'd3
  } cp0_inv_state_e;

endpackage

// File: rtl/cr_cp0_cache_inv.sv
// CP0 I-cache invalidate sequencer: fence.i / invalidate-all walk the sets, icpa issues one address.
// Build option CR_CP0_ICACHE_EN: when undefined there is no I-cache, so requests complete immediately.
module cr_cp0_cache_inv
  import cr_cp0_pkg::*;
#(
  parameter int LINE_NUM = CP0_LINE_NUM_DEF
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  input  logic                        iu_cp0_fencei_req,
  input  logic                        iu_cp0_icall_req,
  input  logic                        iu_cp0_icpa_req,
  input  logic [31:0]                 iu_cp0_icpa_addr,
  output logic                        cp0_iu_cache_inv_done,
  output logic                        cp0_ifu_inv_req,
  output logic                        cp0_ifu_inv_all,
  output logic [$clog2(LINE_NUM)-1:0] cp0_ifu_inv_index,
  output logic [31:0]                 cp0_ifu_inv_addr,
  input  logic                        ifu_cp0_inv_ack,
  output cp0_inv_state_e              cp0_inv_dbg_state
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_NUM - 1);

  // Handshake: cp0_ifu_inv_req is valid, ifu_cp0_inv_ack is ready; a transaction
  // transfers on a rising edge where both are high, and req/payload hold until then.

  cp0_inv_state_e   state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             done_q, inv_req_q, inv_all_q;
  logic             inv_req_d, inv_all_d;
  logic             any_req;

  assign any_req = iu_cp0_fencei_req | iu_cp0_icall_req | iu_cp0_icpa_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
`ifdef CR_CP0_ICACHE_EN
        if (iu_cp0_fencei_req || iu_cp0_icall_req) begin
          state_d = ST_WALK;
          cnt_d   = '0;
          addr_d  = iu_cp0_icpa_addr;
        end else if (iu_cp0_icpa_req) begin
          state_d = ST_PA;
          cnt_d   = '0;
          addr_d  = iu_cp0_icpa_addr;
        end
`else
        if (any_req) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          addr_d  = iu_cp0_icpa_addr;
        end
`endif
      end
      ST_WALK: begin
        // The last set finishes the walk; the counter never wraps back to 0.
        if (ifu_cp0_inv_ack) begin
          if (cnt_q == IDX_LAST) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      ST_PA: begin
        if (ifu_cp0_inv_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!any_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef CR_CP0_ICACHE_EN
    inv_req_d = (state_d == ST_WALK) || (state_d == ST_PA);
    inv_all_d = (state_d == ST_WALK);
`else
    inv_req_d = 1'b0;
    inv_all_d = 1'b0;
`endif
  end

  // Outputs are flops loaded from next state, so nothing combinational reaches them.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      inv_req_q <= 1'b0;
      inv_all_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      done_q    <= (state_d == ST_DONE);
      inv_req_q <= inv_req_d;
      inv_all_q <= inv_all_d;
    end
  end

  assign cp0_iu_cache_inv_done = done_q;
  assign cp0_ifu_inv_req       = inv_req_q;
  assign cp0_ifu_inv_all       = inv_all_q;
  assign cp0_ifu_inv_index     = cnt_q;
  assign cp0_ifu_inv_addr      = addr_q;
  assign cp0_inv_dbg_state     = state_q;

endmodule

// File: tb/tb_cr_cp0_cache_inv.sv
// Scoreboard bench for cr_cp0_cache_inv; covers both CR_CP0_ICACHE_EN builds.
module tb_cr_cp0_cache_inv;
  import cr_cp0_pkg::*;

  localparam int LN      = 64;
  localparam int IW      = $clog2(LN);
  localparam int EW      = 42;
  localparam int TIMEOUT = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fencei = 1'b0, icall = 1'b0, icpa = 1'b0;
  logic [31:0]    icpa_addr = '0;
  logic           ack = 1'b0;
  logic           done, inv_req, inv_all;
  logic [IW-1:0]  inv_index;
  logic [31:0]    inv_addr;
  cp0_inv_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic ack_force = 1'b0;

  // Entry: {kind(1=done,0=txn), all, index[7:0], addr or expected done cycle}
  logic [EW-1:0] exp_q[$];

  cr_cp0_cache_inv #(.LINE_NUM(LN)) dut (
    .forever_cpuclk        (clk),
    .cpurst_b              (rst_n),
    .iu_cp0_fencei_req     (fencei),
    .iu_cp0_icall_req      (icall),
    .iu_cp0_icpa_req       (icpa),
    .iu_cp0_icpa_addr      (icpa_addr),
    .cp0_iu_cache_inv_done (done),
    .cp0_ifu_inv_req       (inv_req),
    .cp0_ifu_inv_all       (inv_all),
    .cp0_ifu_inv_index     (inv_index),
    .cp0_ifu_inv_addr      (inv_addr),
    .ifu_cp0_inv_ack       (ack),
    .cp0_inv_dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_walk(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b1, 8'(i), 32'd0});
  endtask

  task automatic push_pa(input logic [31:0] a);
    exp_q.push_back({1'b0, 1'b0, 8'd0, a});
  endtask

  task automatic push_done(input int at_cycle);
    exp_q.push_back({1'b1, 1'b0, 8'd0, 32'(at_cycle)});
  endtask

  // ---------------- I-cache ack responder ----------------
  always @(posedge clk) begin
    #1;
    if (!rst_n || !inv_req) begin
      wait_cnt = 0;
      ack = ack_force;
    end else begin
      if (ack) wait_cnt = 0;
      ack = ack_force || (wait_cnt >= ack_delay);
      wait_cnt++;
    end
  end

  // ---------------- monitor ----------------
  logic          prev_done = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic [40:0]   prev_pl = '0;
  logic [40:0]   pl, pl_cmp;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    pl     = {inv_all, 8'(inv_index), inv_addr};
    pl_cmp = inv_all ? {1'b1, 8'(inv_index), 32'd0} : {1'b0, 8'd0, inv_addr};
    if (!rst_n) begin
      prev_done = 1'b0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (inv_req && prev_req && !prev_ack)
        check("hold_payload", {1'b0, pl}, {1'b0, prev_pl});
      if (inv_req && ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL txn: got unexpected transaction %0h, required none", pl_cmp);
        end else begin
          mon_e = exp_q.pop_front();
          check("txn", {1'b0, pl_cmp}, mon_e);
        end
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_rise: got unexpected done at cycle %0d, required none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", {1'b1, 9'd0, 32'(cyc)}, mon_e);
        end
      end
      prev_done = done;
      prev_req  = inv_req;
      prev_ack  = ack;
      prev_pl   = pl;
    end
  end

  // ---------------- driver ----------------
  // drop_at: cycle after issue at which requests fall (0 = keep until done);
  // hold_after: extra cycles requests stay high once done is seen.
  task automatic do_op(input logic f, input logic c, input logic p, input logic [31:0] a,
                       input int dly, input int drop_at, input int hold_after, input string tag);
    int start;
    bit seen;
    @(negedge clk);
    ack_delay = dly;
    start = cyc;
`ifdef CR_CP0_ICACHE_EN
    if (f || c) begin
      push_walk(LN);
      push_done(start + 1 + LN * (1 + dly));
    end else begin
      push_pa(a);
      push_done(start + 2 + dly);
    end
`else
    push_done(start + 1);
`endif
    fencei = f;
    icall = c;
    icpa = p;
    icpa_addr = a;
    seen = 1'b0;
    for (int t = 1; t <= TIMEOUT && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (t == drop_at) begin
        fencei = 1'b0;
        icall = 1'b0;
        icpa = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done got 0, required 1 within %0d cycles", tag, TIMEOUT);
    end
    for (int k = 0; k < hold_after; k++) begin
      @(negedge clk);
      check({tag, "_done_held"}, EW'(done), EW'(1));
    end
    fencei = 1'b0;
    icall = 1'b0;
    icpa = 1'b0;
    @(negedge clk);
    check({tag, "_done_drop"}, EW'(done), EW'(0));
    check({tag, "_idle"}, EW'(dbg_state), EW'(ST_IDLE));
    @(negedge clk);
    check({tag, "_no_restart"}, EW'({inv_req, done}), EW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check("rst_done",  EW'(done),      EW'(0));
    check("rst_req",   EW'(inv_req),   EW'(0));
    check("rst_all",   EW'(inv_all),   EW'(0));
    check("rst_index", EW'(inv_index), EW'(0));
    check("rst_addr",  EW'(inv_addr),  EW'(0));
    check("rst_state", EW'(dbg_state), EW'(ST_IDLE));
    rst_n = 1'b1;

`ifdef CR_CP0_ICACHE_EN
    ack_force = 1'b0;
    do_op(1'b0, 1'b1, 1'b0, 32'h1234_5678, 0, 0, 0, "icall_walk");
    do_op(1'b0, 1'b0, 1'b1, 32'h8000_1040, 3, 0, 0, "icpa_dly3");
    do_op(1'b1, 1'b0, 1'b1, 32'hdead_beef, 0, 0, 0, "fencei_icpa");
    do_op(1'b0, 1'b0, 1'b1, 32'h0000_0ffc, 1, 0, 4, "icpa_hold");
    do_op(1'b0, 1'b0, 1'b1, 32'h4000_0000, 3, 1, 0, "icpa_drop");
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1, 3, 0, "fencei_drop");

    // Reset while the walk presents set 20.
    @(negedge clk);
    ack_delay = 0;
    push_walk(21);
    icall = 1'b1;
    found = 1'b0;
    for (int t = 0; t < TIMEOUT && !found; t++) begin
      @(negedge clk);
      if (inv_req && inv_index == IW'(20)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rst_walk_timeout: index 20 got not reached, required within %0d cycles", TIMEOUT);
    end
    #2;
    rst_n = 1'b0;
    icall = 1'b0;
    #1;
    check("rstmid_req",   EW'(inv_req),   EW'(0));
    check("rstmid_done",  EW'(done),      EW'(0));
    check("rstmid_index", EW'(inv_index), EW'(0));
    check("rstmid_state", EW'(dbg_state), EW'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_queue", EW'(exp_q.size()), EW'(0));
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0000, 0, 0, 0, "walk_after_rst");
`else
    ack_force = 1'b1;
    do_op(1'b0, 1'b1, 1'b0, 32'h1234_5678, 0, 0, 0, "icall_noc");
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0000, 0, 0, 0, "fencei_noc");
    do_op(1'b0, 1'b0, 1'b1, 32'h8000_1040, 0, 0, 0, "icpa_noc");
    do_op(1'b1, 1'b1, 1'b1, 32'h0000_0ffc, 0, 0, 4, "all_hold_noc");

    // Reset while in DONE.
    @(negedge clk);
    push_done(cyc + 1);
    icall = 1'b1;
    @(negedge clk);
    check("rstdone_pre", EW'(done), EW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstdone_done",  EW'(done),      EW'(0));
    check("rstdone_req",   EW'(inv_req),   EW'(0));
    check("rstdone_state", EW'(dbg_state), EW'(ST_IDLE));
    icall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0000, 0, 0, 0, "icall_after_rst");
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cr_cp0_cache_inv.md
CR_CP0_CACHE_INV -- requirements
Module: cr_cp0_cache_inv

Interface
REQ-001 SHALL have parameter LINE_NUM, default 64: number of I-cache sets walked by an invalidate-all; power of two, 2..256.
REQ-002 SHALL have port forever_cpuclk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpurst_b, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port iu_cp0_fencei_req, input, 1: fence.i request, held high by the IU until done is observed.
REQ-005 SHALL have port iu_cp0_icall_req, input, 1: invalidate-all request, held high by the IU.
REQ-006 SHALL have port iu_cp0_icpa_req, input, 1: invalidate-by-physical-address request, held high by the IU.
REQ-007 SHALL have port iu_cp0_icpa_addr, input, 32: physical address for icpa; sampled on acceptance.
REQ-008 SHALL have port cp0_iu_cache_inv_done, output, 1: operation complete.
REQ-009 SHALL have port cp0_ifu_inv_req, output, 1: invalidate-transaction valid to the I-cache.
REQ-010 SHALL have port cp0_ifu_inv_all, output, 1: 1 means a set-index transaction; 0 means an address transaction.
REQ-011 SHALL have port cp0_ifu_inv_index, output, log2(LINE_NUM): set index when inv_all=1.
REQ-012 SHALL have port cp0_ifu_inv_addr, output, 32: address when inv_all=0.
REQ-013 SHALL have port ifu_cp0_inv_ack, input, 1: the I-cache accepted the current transaction this cycle.

Function
REQ-014 SHALL implement the FSM states IDLE, WALK, PA and DONE.
REQ-015 SHALL move IDLE->WALK when fencei or icall is high, and IDLE->PA when only icpa is high; fencei/icall take priority over icpa.
REQ-016 SHALL, on IDLE exit, clear the index counter to 0 and latch icpa_addr.
REQ-017 SHALL, in WALK, drive inv_req=1, inv_all=1 and inv_index=counter.
REQ-018 SHALL, in WALK, increment the counter on ack; on ack with counter==LINE_NUM-1, go to DONE (no wrap to 0 is issued).
REQ-019 SHALL, in PA, drive inv_req=1, inv_all=0 and inv_addr=latched address; on ack, go to DONE.
REQ-020 SHALL hold inv_req and its payload stable while ack is low.
REQ-021 SHALL drive cp0_iu_cache_inv_done=1 only in DONE, and 0 in all other states.
REQ-022 SHALL go DONE->IDLE in the first cycle all three requests are low; while any request remains high, SHALL stay in DONE.
REQ-023 SHALL run a started operation to completion if its request drops mid-operation; done then pulses for one cycle.
REQ-024 SHALL have a minimum latency, request high to done high, of LINE_NUM+1 cycles for walk and 2 cycles for PA with ack tied high.
REQ-025 SHALL register all outputs, with no combinational path from request inputs to done.

Reset
REQ-026 SHALL, on cpurst_b low, immediately go to IDLE, clear the counter and address, and drive done=0 and inv_req=0, including mid-walk.
REQ-027 SHALL reset inv_all, inv_index and inv_addr to 0.

Configuration
REQ-028 SHALL, with CR_CP0_ICACHE_EN defined, behave as in REQ-014..025.
REQ-029 SHALL, with CR_CP0_ICACHE_EN undefined, go IDLE->DONE directly (done one cycle after request), keep inv_req at 0 and ignore ack.

Structure
REQ-030 SHALL put the FSM state encodings (2-bit) and the default LINE_NUM in the shared package cr_cp0_pkg.
REQ-031 SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-032 SHALL cover: icall, LINE_NUM=64, ack tied 1 -> index 0..63 issued once each; done rises at cycle 65; no index 64.
REQ-033 SHALL cover: icpa with addr 0x8000_1040 and ack delayed 3 cycles -> inv_addr=0x8000_1040 held 4 cycles, inv_all=0; done follows ack by 1 cycle.
REQ-034 SHALL cover: fencei and icpa high together -> walk performed, no PA transaction.
REQ-035 SHALL cover: request held 5 cycles after done -> done stays 1 for 5 cycles, IDLE one cycle after drop, no new walk.
REQ-036 SHALL cover: cpurst_b low at index 20 -> inv_req=0 and done=0 asynchronously; after release, a new icall restarts at index 0.
REQ-037 SHALL cover: CR_CP0_ICACHE_EN undefined, icall -> done=1 next cycle, inv_req never 1.
